// File: rtl/tcp_rx_msg_poller.sv
// ---------------------------------------------------------------------------
// tcp_rx_msg_poller
//
// Purpose:
//   Queues application message requests ("give me LEN bytes of flow F") and
//   polls the per-flow RX pointer store until enough committed payload is
//   available. A satisfied request is emitted as a metadata beat that
//   describes the head buffer. An unsatisfied request goes back to the tail
//   of the queue, so other flows can make progress while it waits.
//
// Optional feature:
//   TCP_RX_POLLER_REQUEUE_CNT_EN - adds poller_requeue_cnt[15:0], a
//   saturating count of requeue events.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   noc_if_poller_msg_req_*             incoming request (val/rdy + fields)
//   poller_rx_ptrs_rd_req_*             pointer-store read request
//   rx_ptrs_poller_rd_req_rdy           pointer-store read accept
//   rx_ptrs_poller_rd_resp_*            pointer-store read response
//   poller_rx_ptrs_rd_resp_rdy          response accept
//   poller_msg_noc_if_*                 satisfied-request metadata out
//   noc_if_poller_msg_meta_rdy          downstream accept
//   poller_requeue_cnt                  requeue counter (optional)
//
// head_buf layout: {idx[TCP_BUF_IDX_W], addr[POLL_PTR_W], size[RX_PAYLOAD_PTR_W]}
// ---------------------------------------------------------------------------
module tcp_rx_msg_poller #(
    parameter int FLOWID_W         = 8,
    parameter int RX_PAYLOAD_PTR_W = 16,
    parameter int MSG_SRC_X_WIDTH  = 4,
    parameter int MSG_SRC_Y_WIDTH  = 4,
    parameter int XY_WIDTH         = 8,
    parameter int NOC_FBITS_WIDTH  = 4,
    parameter int TCP_BUF_IDX_W    = 8,
    parameter int REQ_Q_DEPTH      = 8,
    parameter int POLL_PTR_W       = RX_PAYLOAD_PTR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        noc_if_poller_msg_req_val,
    input  logic [FLOWID_W-1:0]         noc_if_poller_msg_req_flowid,
    input  logic [RX_PAYLOAD_PTR_W-1:0] noc_if_poller_msg_req_len,
    input  logic [MSG_SRC_X_WIDTH-1:0]  noc_if_poller_msg_dst_x,
    input  logic [MSG_SRC_Y_WIDTH-1:0]  noc_if_poller_msg_dst_y,
    input  logic [NOC_FBITS_WIDTH-1:0]  noc_if_poller_msg_dst_fbits,
    output logic                        poller_noc_if_msg_req_rdy,

    output logic                        poller_rx_ptrs_rd_req_val,
    output logic [FLOWID_W-1:0]         poller_rx_ptrs_rd_req_addr,
    input  logic                        rx_ptrs_poller_rd_req_rdy,

    input  logic                        rx_ptrs_poller_rd_resp_val,
    input  logic [POLL_PTR_W-1:0]       rx_ptrs_poller_rd_resp_head_ptr,
    input  logic [POLL_PTR_W-1:0]       rx_ptrs_poller_rd_resp_commit_ptr,
    input  logic [TCP_BUF_IDX_W-1:0]    rx_ptrs_poller_rd_resp_head_idx,
    output logic                        poller_rx_ptrs_rd_resp_rdy,

    output logic                        poller_msg_noc_if_meta_val,
    output logic [FLOWID_W-1:0]         poller_msg_noc_if_flowid,
    output logic [TCP_BUF_IDX_W+POLL_PTR_W+RX_PAYLOAD_PTR_W-1:0] poller_msg_noc_if_head_buf,
    output logic [XY_WIDTH-1:0]         poller_msg_noc_if_dst_x,
    output logic [XY_WIDTH-1:0]         poller_msg_noc_if_dst_y,
    output logic [NOC_FBITS_WIDTH-1:0]  poller_msg_noc_if_dst_fbits,
    input  logic                        noc_if_poller_msg_meta_rdy
`ifdef TCP_RX_POLLER_REQUEUE_CNT_EN
    ,
    output logic [15:0]                 poller_requeue_cnt
`endif
);

    localparam int AW    = $clog2(REQ_Q_DEPTH);
    localparam int CMP_W = (POLL_PTR_W > RX_PAYLOAD_PTR_W) ? POLL_PTR_W : RX_PAYLOAD_PTR_W;

    typedef struct packed {
        logic [FLOWID_W-1:0]         flowid;
        logic [RX_PAYLOAD_PTR_W-1:0] len;
        logic [MSG_SRC_X_WIDTH-1:0]  dst_x;
        logic [MSG_SRC_Y_WIDTH-1:0]  dst_y;
        logic [NOC_FBITS_WIDTH-1:0]  fbits;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        CHECK,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    req_t                      work_q, work_d;
    logic [POLL_PTR_W-1:0]     head_ptr_q, head_ptr_d;
    logic [POLL_PTR_W-1:0]     commit_ptr_q, commit_ptr_d;
    logic [TCP_BUF_IDX_W-1:0]  head_idx_q, head_idx_d;

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    // Holds req_rdy low through reset and the first cycle after it.
    logic                      rdy_en_q;

    req_t                      mem_q [REQ_Q_DEPTH];

    logic                      busy;
    logic [AW:0]               occupancy;
    logic                      full;
    logic                      requeue;
    logic                      pop;
    logic                      push;
    logic                      wr_en;
    req_t                      wr_data;
    req_t                      req_in;
    logic [POLL_PTR_W-1:0]     avail;
    logic                      satisfied;

    // The request in the working register still owns its FIFO slot until it
    // leaves through OUT; counting it here is what guarantees that a requeue
    // always finds a free slot.
    assign busy      = (state_q != IDLE);
    assign occupancy = count_q + (AW+1)'(busy);
    assign full      = (occupancy >= (AW+1)'(REQ_Q_DEPTH));

    assign avail     = commit_ptr_q - head_ptr_q;
    assign satisfied = (CMP_W'(avail) >= CMP_W'(work_q.len));
    assign requeue   = (state_q == CHECK) && !satisfied;

    assign poller_noc_if_msg_req_rdy = rdy_en_q && !full && !requeue;
    assign push    = noc_if_poller_msg_req_val && poller_noc_if_msg_req_rdy;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign wr_en   = push || requeue;

    assign req_in.flowid = noc_if_poller_msg_req_flowid;
    assign req_in.len    = noc_if_poller_msg_req_len;
    assign req_in.dst_x  = noc_if_poller_msg_dst_x;
    assign req_in.dst_y  = noc_if_poller_msg_dst_y;
    assign req_in.fbits  = noc_if_poller_msg_dst_fbits;
    assign wr_data       = requeue ? work_q : req_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        head_ptr_d   = head_ptr_q;
        commit_ptr_d = commit_ptr_q;
        head_idx_d   = head_idx_q;
        poller_rx_ptrs_rd_req_val  = 1'b0;
        poller_rx_ptrs_rd_resp_rdy = 1'b0;
        poller_msg_noc_if_meta_val = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    work_d  = mem_q[rd_ptr_q];
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                poller_rx_ptrs_rd_req_val = 1'b1;
                if (rx_ptrs_poller_rd_req_rdy) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                poller_rx_ptrs_rd_resp_rdy = 1'b1;
                if (rx_ptrs_poller_rd_resp_val) begin
                    head_ptr_d   = rx_ptrs_poller_rd_resp_head_ptr;
                    commit_ptr_d = rx_ptrs_poller_rd_resp_commit_ptr;
                    head_idx_d   = rx_ptrs_poller_rd_resp_head_idx;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                state_d = satisfied ? OUT : IDLE;
            end
            OUT: begin
                poller_msg_noc_if_meta_val = 1'b1;
                if (noc_if_poller_msg_meta_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            work_q       <= '0;
            head_ptr_q   <= '0;
            commit_ptr_q <= '0;
            head_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            head_ptr_q   <= head_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            head_idx_q   <= head_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rdy_en_q     <= 1'b1;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign poller_rx_ptrs_rd_req_addr  = work_q.flowid;
    assign poller_msg_noc_if_flowid    = work_q.flowid;
    assign poller_msg_noc_if_head_buf  = {head_idx_q, head_ptr_q, work_q.len};
    assign poller_msg_noc_if_dst_x     = XY_WIDTH'(work_q.dst_x);
    assign poller_msg_noc_if_dst_y     = XY_WIDTH'(work_q.dst_y);
    assign poller_msg_noc_if_dst_fbits = work_q.fbits;

`ifdef TCP_RX_POLLER_REQUEUE_CNT_EN
    logic [15:0] requeue_cnt_q, requeue_cnt_d;

    always_comb begin
        requeue_cnt_d = requeue_cnt_q;
        if (requeue && (requeue_cnt_q != 16'hFFFF)) begin
            requeue_cnt_d = requeue_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            requeue_cnt_q <= '0;
        end else begin
            requeue_cnt_q <= requeue_cnt_d;
        end
    end

    assign poller_requeue_cnt = requeue_cnt_q;
`endif

endmodule

// File: tb/tb_tcp_rx_msg_poller.sv
// ---------------------------------------------------------------------------
// tb_tcp_rx_msg_poller
//
// Directed bench for tcp_rx_msg_poller with default parameters (8-bit flow
// id, 16-bit pointers, 8-bit buffer index, depth 8). Inputs change and
// outputs are sampled 1 ns after the rising edge. The pointer store always
// accepts reads and, unless a test says otherwise, always presents a valid
// response taken from resp_head/resp_commit/resp_idx.
// ---------------------------------------------------------------------------
module tb_tcp_rx_msg_poller;

    logic        clk;
    logic        rst_n;
    logic        req_val;
    logic [7:0]  req_flowid;
    logic [15:0] req_len;
    logic [3:0]  req_dst_x;
    logic [3:0]  req_dst_y;
    logic [3:0]  req_fbits;
    logic        req_rdy;
    logic        rd_req_val;
    logic [7:0]  rd_req_addr;
    logic        rd_req_rdy;
    logic        rd_resp_val;
    logic [15:0] resp_head;
    logic [15:0] resp_commit;
    logic [7:0]  resp_idx;
    logic        rd_resp_rdy;
    logic        meta_val;
    logic [7:0]  meta_flowid;
    logic [39:0] meta_head_buf;
    logic [7:0]  meta_dst_x;
    logic [7:0]  meta_dst_y;
    logic [3:0]  meta_fbits;
    logic        meta_rdy;
`ifdef TCP_RX_POLLER_REQUEUE_CNT_EN
    logic [15:0] requeue_cnt;
`endif

    int errors = 0;
    int checks = 0;

    tcp_rx_msg_poller dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .noc_if_poller_msg_req_val         (req_val),
        .noc_if_poller_msg_req_flowid      (req_flowid),
        .noc_if_poller_msg_req_len         (req_len),
        .noc_if_poller_msg_dst_x           (req_dst_x),
        .noc_if_poller_msg_dst_y           (req_dst_y),
        .noc_if_poller_msg_dst_fbits       (req_fbits),
        .poller_noc_if_msg_req_rdy         (req_rdy),
        .poller_rx_ptrs_rd_req_val         (rd_req_val),
        .poller_rx_ptrs_rd_req_addr        (rd_req_addr),
        .rx_ptrs_poller_rd_req_rdy         (rd_req_rdy),
        .rx_ptrs_poller_rd_resp_val        (rd_resp_val),
        .rx_ptrs_poller_rd_resp_head_ptr   (resp_head),
        .rx_ptrs_poller_rd_resp_commit_ptr (resp_commit),
        .rx_ptrs_poller_rd_resp_head_idx   (resp_idx),
        .poller_rx_ptrs_rd_resp_rdy        (rd_resp_rdy),
        .poller_msg_noc_if_meta_val        (meta_val),
        .poller_msg_noc_if_flowid          (meta_flowid),
        .poller_msg_noc_if_head_buf        (meta_head_buf),
        .poller_msg_noc_if_dst_x           (meta_dst_x),
        .poller_msg_noc_if_dst_y           (meta_dst_y),
        .poller_msg_noc_if_dst_fbits       (meta_fbits),
        .noc_if_poller_msg_meta_rdy        (meta_rdy)
`ifdef TCP_RX_POLLER_REQUEUE_CNT_EN
        ,
        .poller_requeue_cnt                (requeue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded). Returns 1 ns
    // after the accepting edge.
    task automatic send_req(input logic [7:0] fl, input logic [15:0] len,
                            input logic [3:0] x, input logic [3:0] y,
                            input logic [3:0] fb);
        bit ok;
        ok         = 1'b0;
        req_val    = 1'b1;
        req_flowid = fl;
        req_len    = len;
        req_dst_x  = x;
        req_dst_y  = y;
        req_fbits  = fb;
        for (int i = 0; i < 50; i++) begin
            if (req_rdy) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_val = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_req_accept flow=%0h len=%0d got no accept, required accept within 50 cycles", fl, len);
        end
    endtask

    task automatic wait_meta(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (meta_val) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_rdy, rd_req_val, rd_resp_rdy, meta_val} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_vals got %b required 0000", {req_rdy, rd_req_val, rd_resp_rdy, meta_val});
        end
        checks++;
        if ({rd_req_addr, meta_flowid, meta_head_buf, meta_dst_x, meta_dst_y, meta_fbits} !== 76'd0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", {rd_req_addr, meta_flowid, meta_head_buf, meta_dst_x, meta_dst_y, meta_fbits});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy got %b required 1", req_rdy);
        end
        $display("reset: done");
    endtask

    task automatic test_latency();
        resp_head   = 16'h0100;
        resp_commit = 16'h0140;
        resp_idx    = 8'h5A;
        send_req(8'd3, 16'd64, 4'h3, 4'hA, 4'h6);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (meta_val !== (i == 4)) begin
                errors++;
                $display("FAIL latency_cycle%0d meta_val got %b required %b", i, meta_val, (i == 4));
            end
        end
        checks++;
        if (meta_flowid !== 8'd3 || meta_head_buf !== {8'h5A, 16'h0100, 16'd64}) begin
            errors++;
            $display("FAIL latency_fields flow=%h buf=%h required flow=03 buf=%h", meta_flowid, meta_head_buf, {8'h5A, 16'h0100, 16'd64});
        end
        checks++;
        if (meta_dst_x !== 8'h03 || meta_dst_y !== 8'h0A || meta_fbits !== 4'h6) begin
            errors++;
            $display("FAIL latency_dst x=%h y=%h fb=%h required 03 0a 6", meta_dst_x, meta_dst_y, meta_fbits);
        end
        tick();
        checks++;
        if (meta_val !== 1'b0) begin
            errors++;
            $display("FAIL latency_handshake meta_val got %b required 0", meta_val);
        end
        $display("latency: flow 3 len 64 -> flow=%0d buf=%h", 3, {8'h5A, 16'h0100, 16'd64});
    endtask

    task automatic test_wrap();
        bit found;
        resp_head   = 16'hFFF0;
        resp_commit = 16'h0010;
        resp_idx    = 8'h21;
        send_req(8'd9, 16'd32, 4'h1, 4'h2, 4'h3);
        wait_meta(20, found);
        checks++;
        if (!found || meta_head_buf !== {8'h21, 16'hFFF0, 16'd32} || meta_flowid !== 8'd9) begin
            errors++;
            $display("FAIL wrap_meta found=%b flow=%h buf=%h required 1 09 %h", found, meta_flowid, meta_head_buf, {8'h21, 16'hFFF0, 16'd32});
        end
        tick();
        $display("wrap: head=fff0 commit=0010 len 32 -> found=%b", found);
    endtask

    task automatic test_len_zero();
        bit found;
        resp_head   = 16'h0200;
        resp_commit = 16'h0200;
        resp_idx    = 8'h07;
        send_req(8'd4, 16'd0, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 4; i++) tick();
        found = meta_val;
        checks++;
        if (found !== 1'b1 || meta_head_buf !== {8'h07, 16'h0200, 16'd0}) begin
            errors++;
            $display("FAIL len_zero meta_val=%b buf=%h required 1 %h", found, meta_head_buf, {8'h07, 16'h0200, 16'd0});
        end
        tick();
        $display("len_zero: avail 0 len 0 -> meta_val=%b", found);
    endtask

    task automatic test_requeue();
        bit found;
        resp_head   = 16'h0000;
        resp_commit = 16'd50;
        resp_idx    = 8'h33;
        send_req(8'd6, 16'd100, 4'h5, 4'h5, 4'h1);
        tick();
        tick();
        checks++;
        if (rd_resp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL requeue_rd_resp_rdy got %b required 1", rd_resp_rdy);
        end
        tick();
        checks++;
        if (req_rdy !== 1'b0 || meta_val !== 1'b0) begin
            errors++;
            $display("FAIL requeue_check_cycle req_rdy=%b meta_val=%b required 0 0", req_rdy, meta_val);
        end
        resp_commit = 16'd100;
        tick();
        checks++;
        if (meta_val !== 1'b0) begin
            errors++;
            $display("FAIL requeue_no_early_meta got %b required 0", meta_val);
        end
        wait_meta(20, found);
        checks++;
        if (!found || meta_head_buf !== {8'h33, 16'h0000, 16'd100} || meta_flowid !== 8'd6) begin
            errors++;
            $display("FAIL requeue_meta found=%b flow=%h buf=%h required 1 06 %h", found, meta_flowid, meta_head_buf, {8'h33, 16'h0000, 16'd100});
        end
`ifdef TCP_RX_POLLER_REQUEUE_CNT_EN
        checks++;
        if (requeue_cnt !== 16'd1) begin
            errors++;
            $display("FAIL requeue_cnt got %0d required 1", requeue_cnt);
        end
`endif
        tick();
        $display("requeue: len 100 avail 50 then 100 -> found=%b", found);
    endtask

    task automatic test_back_to_back();
        int k;
        resp_head   = 16'h0000;
        resp_commit = 16'h1000;
        resp_idx    = 8'h11;
        meta_rdy    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_req(8'd5, 16'(i + 1), 4'h2, 4'h4, 4'h8);
        end
        checks++;
        if (req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_req_rdy got %b required 0", req_rdy);
        end
        req_val    = 1'b1;
        req_flowid = 8'd5;
        req_len    = 16'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL full_hold_rdy cycle%0d got %b required 0", i, req_rdy);
            end
        end
        req_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (meta_val !== 1'b1 || meta_flowid !== 8'd5 || meta_head_buf !== {8'h11, 16'h0000, 16'd1}
                || meta_dst_x !== 8'h02 || meta_dst_y !== 8'h04 || meta_fbits !== 4'h8) begin
                errors++;
                $display("FAIL stall_stable cycle%0d val=%b flow=%h buf=%h required 1 05 %h", i, meta_val, meta_flowid, meta_head_buf, {8'h11, 16'h0000, 16'd1});
            end
            tick();
        end
        meta_rdy = 1'b1;
        k = 0;
        for (int c = 0; c < 100 && k < 8; c++) begin
            if (meta_val) begin
                checks++;
                if (meta_head_buf[15:0] !== 16'(k + 1)) begin
                    errors++;
                    $display("FAIL drain_order meta%0d size got %0d required %0d", k, meta_head_buf[15:0], k + 1);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL drain_count got %0d required 8", k);
        end
        $display("back_to_back: 8 requests drained=%0d", k);
    endtask

    task automatic test_reset_mid();
        bit seen;
        rd_resp_val = 1'b0;
        seen        = 1'b0;
        send_req(8'd2, 16'd1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            if (rd_resp_rdy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_reach_rd_resp got 0 required 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_rdy, rd_req_val, rd_resp_rdy, meta_val} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_vals got %b required 0000", {req_rdy, rd_req_val, rd_resp_rdy, meta_val});
        end
        tick();
        tick();
        rst_n       = 1'b1;
        rd_resp_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rd_resp_rdy, rd_req_val, meta_val} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_late_resp cycle%0d resp_rdy/rd_req/meta got %b required 000", i, {rd_resp_rdy, rd_req_val, meta_val});
            end
        end
        $display("reset_mid: reset in RD_RESP, late response ignored");
    endtask

    initial begin
        rst_n       = 1'b0;
        req_val     = 1'b0;
        req_flowid  = '0;
        req_len     = '0;
        req_dst_x   = '0;
        req_dst_y   = '0;
        req_fbits   = '0;
        rd_req_rdy  = 1'b1;
        rd_resp_val = 1'b1;
        resp_head   = '0;
        resp_commit = '0;
        resp_idx    = '0;
        meta_rdy    = 1'b1;
        tick();
        test_reset();
        test_latency();
        test_wrap();
        test_len_zero();
        test_requeue();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcp_rx_msg_poller.md
TCP_RX_MSG_POLLER -- requirements
Module: tcp_rx_msg_poller

Interface
REQ-001 Parameter REQ_Q_DEPTH, default 8, sets the pending-request queue depth; it SHALL be a power of two and at least 2.
REQ-002 Parameter POLL_PTR_W, default RX_PAYLOAD_PTR_W, sets the payload pointer width used for occupancy arithmetic.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- noc_if_poller_msg_req_val  in  1  message request valid
- noc_if_poller_msg_req_flowid  in  FLOWID_W  flow
- noc_if_poller_msg_req_len  in  RX_PAYLOAD_PTR_W  bytes requested
- noc_if_poller_msg_dst_x / _dst_y  in  MSG_SRC_X_WIDTH / MSG_SRC_Y_WIDTH  reply destination
- noc_if_poller_msg_dst_fbits  in  NOC_FBITS_WIDTH  reply fbits
- poller_noc_if_msg_req_rdy  out  1  request accept
- poller_rx_ptrs_rd_req_val  out  1  pointer read request
- poller_rx_ptrs_rd_req_addr  out  FLOWID_W  flow to read
- rx_ptrs_poller_rd_req_rdy  in  1  read accept
- rx_ptrs_poller_rd_resp_val  in  1  read response valid
- rx_ptrs_poller_rd_resp_head_ptr  in  POLL_PTR_W  app head pointer
- rx_ptrs_poller_rd_resp_commit_ptr  in  POLL_PTR_W  committed pointer
- rx_ptrs_poller_rd_resp_head_idx  in  tcp_buf_idx  head buffer index
- poller_rx_ptrs_rd_resp_rdy  out  1  response accept
- poller_msg_noc_if_meta_val  out  1  satisfied request valid
- poller_msg_noc_if_flowid  out  FLOWID_W  flow
- poller_msg_noc_if_head_buf  out  tcp_buf_with_idx  {idx=head_idx, addr=head_ptr, size=req len}
- poller_msg_noc_if_dst_x / _dst_y  out  XY_WIDTH  reply destination, zero-extended
- poller_msg_noc_if_dst_fbits  out  NOC_FBITS_WIDTH  reply fbits
- noc_if_poller_msg_meta_rdy  in  1  downstream accept

Function
REQ-004 A transfer SHALL occur on any interface only in a cycle where val and rdy are both high.
REQ-005 Accepted requests SHALL enter a FIFO of REQ_Q_DEPTH entries holding flowid, len, dst_x, dst_y and fbits.
REQ-006 poller_noc_if_msg_req_rdy SHALL be high iff the FIFO is not full and no requeue write occurs that cycle.
REQ-007 The FSM SHALL have states IDLE, RD_REQ, RD_RESP, CHECK and OUT.
REQ-008 IDLE SHALL pop the FIFO head into a working register when the FIFO is non-empty and go to RD_REQ.
REQ-009 RD_REQ SHALL hold rd_req_val high with addr equal to the working flowid, and go to RD_RESP on handshake.
REQ-010 RD_RESP SHALL hold resp_rdy high, register the head pointer, commit pointer and head index on handshake, and go to CHECK.
REQ-011 CHECK SHALL compute avail = (commit_ptr - head_ptr) mod 2^POLL_PTR_W.
REQ-012 If avail >= len, CHECK SHALL go to OUT; otherwise it SHALL write the working request to the FIFO tail (requeue) and go to IDLE.
REQ-013 A requeue SHALL always succeed, because the entry was popped earlier and the slot is free; a requeue write SHALL take priority over a new request in the same cycle.
REQ-014 A len of 0 SHALL be satisfied on the first check.
REQ-015 OUT SHALL hold meta_val high with all meta fields stable until the handshake, then go to IDLE.
REQ-016 Minimum latency from request accept into an empty FIFO to meta_val high SHALL be 4 cycles, given same-cycle rd_req_rdy and a 1-cycle read response.
REQ-017 Requests for the same flow SHALL be emitted in arrival order unless requeued; requests for different flows carry no ordering guarantee.

Reset
REQ-018 Asserting rst_n low SHALL immediately set the FSM to IDLE, empty the FIFO, discard any in-flight request and drive every val/rdy output low; data outputs SHALL be 0.
REQ-019 A read response arriving after reset SHALL be ignored until a new rd_req is issued; resp_rdy SHALL be low outside RD_RESP.

Configuration
REQ-020 With macro TCP_RX_POLLER_REQUEUE_CNT_EN defined, the block SHALL add output port poller_requeue_cnt [15:0], which increments once per requeue, saturates at 0xFFFF and resets to 0.
REQ-021 Without TCP_RX_POLLER_REQUEUE_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-022 Flow 3, len 64, commit=0x140, head=0x100 -> one meta: flowid 3, addr 0x100, size 64, 4 cycles after accept.
REQ-023 Wrap case, head=0xFFF0, commit=0x0010 (16-bit pointers), len 32 -> avail=32, request satisfied.
REQ-024 len 100, avail 50 on first poll, commit then advanced to give avail 100 -> request requeued once, then emitted; poller_requeue_cnt=1 when the macro is defined.
REQ-025 Fill 8 requests with meta_rdy low -> req_rdy low once the FIFO is full; meta fields held stable across 10 stall cycles.
REQ-026 rst_n asserted while in RD_RESP -> all val outputs low immediately, FIFO empty, and a late response is not consumed.
